ram_bist_ctrl: RTL and testbench

//  Upstream stage for the RAM4k word memory. It drives the RAM's in/address/load and consumes its out.
//  On a start pulse it runs a 4-phase march test: W0 P, R0 P, W1 ~P, R1 ~P, across all 2^ADDR_W words.
//  It reports pass/fail and captures the first failing address and its read data.
//  It also serves as the power-on fill engine: after a run the RAM holds ~P(a).

---
 rtl/ram_bist_pkg.sv | 19 +
 rtl/ram_bist_pattern.sv | 19 +
 rtl/ram_bist_ctrl.sv | 123 ++++++++++++
 tb/tb_ram_bist_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and defaults for the RAM march-test controller.
// Optional error counter is enabled with RAM_BIST_ERRCNT_EN.
package ram_bist_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_ADDR_W  = 6;
  localparam logic [15:0] DEF_PATTERN = 16'hA5C3;
  localparam int unsigned ERRCNT_W    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StW0,
    StR0,
    StW1,
    StR1,
    StDone
  } bist_state_e;

endpackage

// File: rtl/ram_bist_pattern.sv
// Address-seeded test pattern: P(a) = PATTERN ^ a, optionally inverted.
module ram_bist_pattern
  import ram_bist_pkg::*;
#(
  parameter int unsigned        DATA_W  = DEF_DATA_W,
  parameter int unsigned        ADDR_W  = DEF_ADDR_W,
  parameter logic [DATA_W-1:0]  PATTERN = DATA_W'(DEF_PATTERN)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              invert,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] base;

  assign base    = PATTERN ^ DATA_W'(addr);
  assign pattern = invert ? ~base : base;

endmodule

// File: rtl/ram_bist_ctrl.sv
// Four-phase march test (W0 P, R0 P, W1 ~P, R1 ~P) and power-on fill engine for a word RAM.
// Define RAM_BIST_ERRCNT_EN to add a saturating mismatch counter on err_count.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned       DATA_W  = DEF_DATA_W,
  parameter int unsigned       ADDR_W  = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
`ifdef RAM_BIST_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  bist_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q, done_q, load_q, pass_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic [DATA_W-1:0] pat;
  logic              invert, is_read, mismatch, addr_max, start_run;

  // One generator serves both the write data and the read compare.
  assign invert    = (state_q == StW1) || (state_q == StR1);
  assign is_read   = (state_q == StR0) || (state_q == StR1);
  assign mismatch  = is_read && (mem_out != pat);
  assign addr_max  = &addr_q;
  assign start_run = (state_q == StIdle) && start;

  ram_bist_pattern #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .PATTERN (PATTERN)
  ) u_pattern (
    .addr    (addr_q),
    .invert  (invert),
    .pattern (pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
      pass_q      <= 1'b1;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (mismatch && pass_q) begin
        pass_q      <= 1'b0;
        fail_addr_q <= addr_q;
        fail_data_q <= mem_out;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StW0;
            addr_q      <= '0;
            busy_q      <= 1'b1;
            load_q      <= 1'b1;
            pass_q      <= 1'b1;
            fail_addr_q <= '0;
            fail_data_q <= '0;
          end
        end
        StW0, StR0, StW1, StR1: begin
          addr_q <= addr_q + 1'b1;
          if (addr_max) begin
            unique case (state_q)
              StW0:    begin state_q <= StR0; load_q <= 1'b0; end
              StR0:    begin state_q <= StW1; load_q <= 1'b1; end
              StW1:    begin state_q <= StR1; load_q <= 1'b0; end
              default: begin state_q <= StDone; busy_q <= 1'b0; done_q <= 1'b1; end
            endcase
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;
  assign mem_load    = load_q;
  assign mem_address = addr_q;
  assign mem_in      = load_q ? pat : '0;

`ifdef RAM_BIST_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errcnt_q <= '0;
    end else if (start_run) begin
      errcnt_q <= '0;
    end else if (mismatch && (errcnt_q != '1)) begin
      errcnt_q <= errcnt_q + 1'b1;
    end
  end

  assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with injectable stuck bits and a cycle-index model.
module tb_ram_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, mem_load;
  logic [5:0]  fail_addr, mem_address;
  logic [15:0] fail_data, mem_in, mem_out;
`ifdef RAM_BIST_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #2 clk = ~clk;

  ram_bist_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data),
    .mem_in      (mem_in),
    .mem_address (mem_address),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
`ifdef RAM_BIST_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  // Behavioural RAM with per-address stuck-at fault injection on the read port.
  logic [15:0] ram [64];
  bit          f_en  [64];
  int          f_bit [64];
  bit          f_val [64];

  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;

  always_comb begin
    mem_out = ram[mem_address];
    if (f_en[mem_address]) mem_out[f_bit[mem_address]] = f_val[mem_address];
  end

  function automatic logic [15:0] pat(int a, bit inv);
    logic [15:0] p;
    p = 16'hA5C3 ^ 16'(a);
    return inv ? ~p : p;
  endfunction

  function automatic logic [15:0] flt(int a, logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (f_en[a]) r[f_bit[a]] = f_val[a];
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t is the cycle index within a run (-1 idle, 0..255 busy, 256 done cycle).
  int          m_t = -1;
  bit          m_pass = 1'b1;
  logic [5:0]  m_fa = '0;
  logic [15:0] m_fd = '0;
  int          m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= -1; m_pass <= 1'b1; m_fa <= '0; m_fd <= '0; m_err <= 0;
    end else if (m_t < 0) begin
      if (start) begin
        m_t <= 0; m_pass <= 1'b1; m_fa <= '0; m_fd <= '0; m_err <= 0;
      end
    end else if (m_t < 256) begin
      if ((m_t / 64) % 2 == 1 &&
          flt(m_t % 64, pat(m_t % 64, m_t >= 128)) != pat(m_t % 64, m_t >= 128)) begin
        if (m_pass) begin
          m_pass <= 1'b0;
          m_fa   <= 6'(m_t % 64);
          m_fd   <= flt(m_t % 64, pat(m_t % 64, m_t >= 128));
        end
        if (m_err < 255) m_err <= m_err + 1;
      end
      m_t <= m_t + 1;
    end else begin
      m_t <= -1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      automatic bit e_busy = (m_t >= 0) && (m_t < 256);
      automatic int e_addr = e_busy ? m_t % 64 : 0;
      automatic bit e_load = e_busy && ((m_t / 64) % 2 == 0);
      check("busy", busy, e_busy);
      check("done", done, m_t == 256);
      check("mem_load", mem_load, e_load);
      check("mem_address", mem_address, e_addr);
      check("mem_in", mem_in, e_load ? pat(e_addr, m_t >= 128) : 16'h0);
      check("pass", pass, m_pass);
      check("fail_addr", fail_addr, m_fa);
      check("fail_data", fail_data, m_fd);
`ifdef RAM_BIST_ERRCNT_EN
      check("err_count", err_count, m_err);
`endif
    end
  end

  bit          w0_seen;
  logic [15:0] w0_a5;

  task automatic do_run(input int extra_at, input int abort_at,
                        output int busy_cnt, output int done_at);
    busy_cnt = 0;
    done_at  = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy) busy_cnt++;
      if (!w0_seen && mem_load && mem_address == 6'd5) begin
        w0_seen = 1'b1;
        w0_a5   = mem_in;
      end
      start = (i == extra_at);
      if (i == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        done_at = i;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk); start = 1'b0;
    check("run_completes", done_at >= 0, 1);
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 64; a++) begin
      f_en[a] = 1'b0; f_bit[a] = 0; f_val[a] = 1'b0;
    end
  endtask

  initial begin
    int bc, da, na, ab;
    for (int a = 0; a < 64; a++) ram[a] = '0;
    clear_faults();
    #9;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 1);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_data", fail_data, 0);
    check("rst_mem_in", mem_in, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_load", mem_load, 0);
    @(negedge clk); rst_n = 1'b1; chk_en = 1'b1;

    // Good RAM: full run, W0 data at addr 5, final fill contents.
    w0_seen = 1'b0;
    do_run(-1, -1, bc, da);
    check("t1_busy_cycles", bc, 256);
    check("t1_done_at", da, 256);
    check("t1_pass", pass, 1);
    check("t1_fail_addr", fail_addr, 0);
    check("t2_w0_a5_seen", w0_seen, 1);
    check("t2_w0_a5_data", w0_a5, 16'hA5C6);
    check("t2_ram5_fill", ram[5], 16'h5A39);

    // Stuck bit0=0 at 20 and 41, with a start pulse during R0 and one on the DONE cycle.
    f_en[20] = 1'b1; f_bit[20] = 0; f_val[20] = 1'b0;
    f_en[41] = 1'b1; f_bit[41] = 0; f_val[41] = 1'b0;
    do_run(80, -1, bc, da);
    check("t4_done_at", da, 256);
    check("t3_pass", pass, 0);
    check("t3_fail_addr", fail_addr, 20);
    check("t3_fail_data", fail_data, 16'hA5D6);
`ifdef RAM_BIST_ERRCNT_EN
    check("t6_err_count", err_count, 2);
`endif
    clear_faults();
    do_run(256, -1, bc, da);
    repeat (3) @(negedge clk);
    check("start_on_done_ignored", busy, 0);

    // Reset mid-W1 at addr 30: outputs drop at once, no further writes.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (158) @(negedge clk);
    check("t5_addr", mem_address, 30);
    check("t5_load_before", mem_load, 1);
    rst_n = 1'b0;
    #1;
    check("t5_load_async", mem_load, 0);
    check("t5_busy_async", busy, 0);
    repeat (3) @(negedge clk);
    check("t5_ram30_kept", ram[30], 16'hA5DD);
    check("t5_ram31_kept", ram[31], 16'hA5DC);
    rst_n = 1'b1;
    do_run(-1, -1, bc, da);
    check("t5_rerun_busy", bc, 256);
    check("t5_rerun_pass", pass, 1);

    // Randomised runs: random faults, stray starts and occasional aborts.
    for (int r = 0; r < 12; r++) begin
      clear_faults();
      na = $urandom_range(0, 3);
      for (int k = 0; k < na; k++) begin
        automatic int a = $urandom_range(0, 63);
        f_en[a] = 1'b1; f_bit[a] = $urandom_range(0, 15); f_val[a] = $urandom_range(0, 1);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : -1;
      do_run($urandom_range(0, 300), ab, bc, da);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
